// File: rtl/frame_buffer_arbiter.sv
// Single-port frame buffer arbiter: queued capture writes vs. reader requests.
// Optional FB_ARB_STATS_EN adds stall_cycles / drop_count outputs.
module frame_buffer_arbiter #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_WAIT   = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_grant,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wr_idle,
    output logic              overflow,
    input  logic              clear_status
`ifdef FB_ARB_STATS_EN
    ,
    output logic [15:0]       stall_cycles,
    output logic [15:0]       drop_count
`endif
);

    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [7:0]        wait_cnt;
    logic              fifo_empty;
    logic              fifo_full;
    logic              wr_sel;
    logic              push;
    logic              drop;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                        (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    assign head_addr  = fifo_addr[rd_ptr[IDX_W-1:0]];
    assign head_data  = fifo_data[rd_ptr[IDX_W-1:0]];

    // Reads win only on an empty queue or once the reader has starved long enough.
    always_comb begin
        rd_grant  = 1'b0;
        wr_sel    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!reset) begin
            rd_grant = rd_req && (fifo_empty || wait_cnt >= MAX_WAIT_C);
            wr_sel   = !rd_grant && !fifo_empty;
        end
        if (rd_grant) begin
            mem_addr = rd_addr;
        end else if (wr_sel) begin
            mem_addr  = head_addr;
            mem_wdata = head_data;
        end
    end

    assign mem_en  = rd_grant || wr_sel;
    assign mem_we  = wr_sel;
    assign push    = wr_valid && (!fifo_full || wr_sel);
    assign drop    = wr_valid && fifo_full && !wr_sel;
    assign rd_data = rd_valid ? mem_rdata : '0;
    assign wr_idle = reset || (fifo_empty && !wr_valid);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            wait_cnt <= '0;
            rd_valid <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (wr_sel)
                rd_ptr <= rd_ptr + PTR_W'(1);
            rd_valid <= rd_grant;
            if (!rd_req || rd_grant)
                wait_cnt <= '0;
            else if (wait_cnt != 8'hFF)
                wait_cnt <= wait_cnt + 8'd1;
            if (drop)
                overflow <= 1'b1;
            else if (clear_status)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_addr[wr_ptr[IDX_W-1:0]] <= wr_addr;
            fifo_data[wr_ptr[IDX_W-1:0]] <= wr_data;
        end
    end

`ifdef FB_ARB_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            drop_count   <= '0;
        end else if (clear_status) begin
            stall_cycles <= '0;
            drop_count   <= '0;
        end else begin
            if (rd_req && !rd_grant && stall_cycles != 16'hFFFF)
                stall_cycles <= stall_cycles + 16'd1;
            if (drop && drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule

// File: doc/frame_buffer_arbiter.md
Name: frame_buffer_arbiter

Overview:
- Shares the single-port image frame buffer RAM between two requesters: the pixel capture path (write, cannot be stalled) and the image reader (read, request/grant).
- Capture writes enter a small write FIFO.
- Reads are normally serviced only when the FIFO is empty, but a starvation counter forces a read slot after MAX_WAIT cycles.
- Sits between the image sensor data processor, the image reader and the frame buffer RAM; the top-level controller uses wr_idle to know when a captured frame is fully committed before starting a send.

Parameters:
- ADDR_W, 19: frame buffer address width (640x480 = 307200 pixels).
- DATA_W, 12: pixel bit depth.
- FIFO_DEPTH, 4: write FIFO entries; power of two, 2 or more.
- MAX_WAIT, 8: consecutive cycles a pending read may be refused before it is forced; range 1 to 255.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- wr_valid  in  1  capture pixel write strobe; no backpressure.
- wr_addr  in  ADDR_W  capture write address.
- wr_data  in  DATA_W  capture write pixel.
- rd_req  in  1  reader request; held high until rd_grant.
- rd_addr  in  ADDR_W  reader address; stable while rd_req is high.
- rd_grant  out  1  read accepted this cycle (combinational).
- rd_valid  out  1  rd_data valid (one cycle after rd_grant).
- rd_data  out  DATA_W  read pixel.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data; synchronous RAM, 1-cycle latency.
- wr_idle  out  1  FIFO empty and wr_valid low.
- overflow  out  1  sticky: a capture write was dropped.
- clear_status  in  1  synchronous clear of overflow (and of stats when enabled).

Behaviour:
- Reset values:
  - FIFO empty, wait_cnt = 0.
  - rd_grant, rd_valid, mem_en, mem_we, overflow = 0.
  - mem_addr, mem_wdata, rd_data = 0.
  - wr_idle = 1.
- Push: on wr_valid, {wr_addr, wr_data} is pushed at the clock edge.
  - FIFO full and no pop that cycle: the write is dropped and overflow is set.
  - FIFO full with a simultaneous pop: the push is accepted.
- No bypass: a write pushed in cycle T is visible to arbitration at T+1 at the earliest.
- Arbitration each cycle (combinational from registered state):
  - Read is selected when rd_req=1 and (FIFO empty or wait_cnt >= MAX_WAIT).
  - Otherwise write is selected when the FIFO is non-empty.
  - Otherwise idle (mem_en=0).
- Read selected:
  - rd_grant=1, mem_en=1, mem_we=0, mem_addr=rd_addr.
  - wait_cnt is cleared.
  - rd_valid=1 at T+1 with rd_data=mem_rdata (passthrough).
- Write selected:
  - mem_en=1, mem_we=1, mem_addr and mem_wdata taken from the FIFO head; the FIFO pops.
- wait_cnt:
  - Increments (saturating at 255) each cycle rd_req=1 and rd_grant=0.
  - Clears when rd_req=0.
- Worst-case read latency is MAX_WAIT cycles from request to grant.
- Hazard rule: a read of an address with a write still queued returns the old data. The controller must not start a send until wr_idle=1; the arbiter performs no address compare.
- Every cycle carries at most one RAM access.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits wide; full/empty are distinguished by the MSB.
- clear_status takes effect at the next edge. If clear_status and an overflow event occur in the same cycle, overflow stays set.
- Reset mid-operation: queued writes are discarded, a read granted in the prior cycle produces no rd_valid, and all outputs return to reset values.

Optional Feature:
- Macro FB_ARB_STATS_EN.
- Defined: adds outputs stall_cycles (16 bits, saturating count of cycles with rd_req=1 and rd_grant=0) and drop_count (16 bits, saturating count of dropped writes). Both clear on reset or clear_status.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Idle read: FIFO empty, rd_req=1, rd_addr=0x00010, RAM holds 0xABC → rd_grant in the same cycle, mem_we=0, rd_valid=1 with rd_data=0xABC one cycle later.
- Write drain: wr_valid for 3 consecutive cycles to addresses 5, 6, 7 with data 1, 2, 3, no reads → RAM writes to addresses 5, 6, 7 on cycles T+1 to T+3; wr_idle=1 at T+4.
- Starvation: MAX_WAIT=8, wr_valid held every cycle, rd_req held → rd_grant exactly 8 cycles after rd_req rises; no write dropped (FIFO peaks at 2 or fewer entries); overflow=0.
- Overflow: FIFO_DEPTH=4, one forced read slot while the FIFO is full and wr_valid=1 → exactly one write is dropped, overflow=1 and stays set until clear_status; drop_count=1 when FB_ARB_STATS_EN is defined.
- Full with simultaneous pop: FIFO at 4 entries with pop and push in the same cycle → push accepted, overflow stays 0.
- Reset mid-operation: assert reset with 3 writes queued and a read granted in the previous cycle → no rd_valid, no further RAM writes, wr_idle=1, all outputs at reset values.
